// File: rtl/fetch_stage.sv
// MINI-RISC instruction fetch: drives the PC, reads sync IMEM, and owns IF/ID.
// A one-entry skid register catches the in-flight word when decode stalls.
module fetch_stage #(
    parameter int ADDR_W  = 11,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_inc,
    output logic               pc_branch_en,
    output logic [ADDR_W-1:0]  pc_branch_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc
);

    logic               issue;

    logic               inflight_valid_q, inflight_valid_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;

    assign issue          = ~rst & ~stall & ~redirect_en;
    assign imem_addr      = pc_addr;
    assign imem_rd_en     = issue;
    assign pc_inc         = issue;
    assign pc_branch_en   = redirect_en & ~rst;
    assign pc_branch_addr = redirect_addr;

    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;

    always_comb begin
        inflight_valid_d = issue;
        inflight_pc_d    = pc_addr;
        skid_valid_d     = skid_valid_q;
        skid_instr_d     = skid_instr_q;
        skid_pc_d        = skid_pc_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_d       = if_id_pc_q;

        if (redirect_en) begin
            if_id_valid_d    = 1'b0;
            inflight_valid_d = 1'b0;
            skid_valid_d     = 1'b0;
        end else if (stall) begin
            // IMEM data is not held, so park it before it disappears
            if (inflight_valid_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = inflight_pc_q;
            end
        end else if (skid_valid_q) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = skid_instr_q;
            if_id_pc_d    = skid_pc_q;
            skid_valid_d  = 1'b0;
        end else begin
            if_id_valid_d = inflight_valid_q;
            if (inflight_valid_q) begin
                if_id_instr_d = imem_rdata;
                if_id_pc_d    = inflight_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
            skid_valid_q     <= 1'b0;
            skid_instr_q     <= '0;
            skid_pc_q        <= '0;
            if_id_valid_q    <= 1'b0;
            if_id_instr_q    <= '0;
            if_id_pc_q       <= '0;
        end else begin
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            skid_valid_q     <= skid_valid_d;
            skid_instr_q     <= skid_instr_d;
            skid_pc_q        <= skid_pc_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_q       <= if_id_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural PC and sync IMEM beside it.
// IMEM word at address a is a+0x100; a cycle without a read returns 0xDEAD.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [10:0] pc_addr;
    logic        pc_inc;
    logic        pc_branch_en;
    logic [10:0] pc_branch_addr;
    logic [10:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect_en;
    logic [10:0] redirect_addr;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [10:0] if_id_pc;

    int checks;
    int errors;

    fetch_stage #(.ADDR_W(11), .INSTR_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_addr       (pc_addr),
        .pc_inc        (pc_inc),
        .pc_branch_en  (pc_branch_en),
        .pc_branch_addr(pc_branch_addr),
        .imem_addr     (imem_addr),
        .imem_rd_en    (imem_rd_en),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst)               pc_addr <= 11'd0;
        else if (pc_branch_en) pc_addr <= pc_branch_addr;
        else if (pc_inc)       pc_addr <= pc_addr + 11'd1;
    end

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= {5'd0, imem_addr} + 16'h0100;
        else            imem_rdata <= 16'hDEAD;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect_en = 1'b0;
        redirect_addr = 11'd0;
        step();
        step();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr} !== 28'd0) begin
            errors++;
            $display("FAIL reset_ifid got %b/%h/%h want 0/000/0000",
                     if_id_valid, if_id_pc, if_id_instr);
        end
        checks++;
        if ({pc_inc, pc_branch_en, imem_rd_en} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl got inc/br/rd %b%b%b want 000",
                     pc_inc, pc_branch_en, imem_rd_en);
        end
    endtask

    task automatic test_stream();
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_rd_en, pc_inc, imem_addr} !== {2'b11, 11'd0}) begin
            errors++;
            $display("FAIL first_issue got rd/inc %b%b addr %h want 11 000",
                     imem_rd_en, pc_inc, imem_addr);
        end
        step();
        checks++;
        if (if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_e1 got valid %b want 0", if_id_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({if_id_valid, if_id_pc, if_id_instr} !==
                {1'b1, 11'(i), 16'h0100 + 16'(i)}) begin
                errors++;
                $display("FAIL stream_%0d got %b/%h/%h want 1/%h/%h",
                         i, if_id_valid, if_id_pc, if_id_instr,
                         11'(i), 16'h0100 + 16'(i));
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        checks++;
        if ({pc_inc, imem_rd_en} !== 2'b00) begin
            errors++;
            $display("FAIL stall_noinc got inc/rd %b%b want 00",
                     pc_inc, imem_rd_en);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({if_id_valid, if_id_pc, if_id_instr} !==
                {1'b1, 11'd3, 16'h0103}) begin
                errors++;
                $display("FAIL stall_hold_%0d got %b/%h/%h want 1/003/0103",
                         i, if_id_valid, if_id_pc, if_id_instr);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr} !==
            {1'b1, 11'd4, 16'h0104}) begin
            errors++;
            $display("FAIL skid_release got %b/%h/%h want 1/004/0104",
                     if_id_valid, if_id_pc, if_id_instr);
        end
        step();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr} !==
            {1'b1, 11'd5, 16'h0105}) begin
            errors++;
            $display("FAIL no_bubble got %b/%h/%h want 1/005/0105",
                     if_id_valid, if_id_pc, if_id_instr);
        end
        step();
        checks++;
        if ({if_id_valid, if_id_pc} !== {1'b1, 11'd6}) begin
            errors++;
            $display("FAIL after_release got %b/%h want 1/006",
                     if_id_valid, if_id_pc);
        end
    endtask

    task automatic test_redirect();
        redirect_en = 1'b1;
        redirect_addr = 11'h040;
        #1;
        checks++;
        if ({pc_branch_en, pc_inc, imem_rd_en, pc_branch_addr} !==
            {3'b100, 11'h040}) begin
            errors++;
            $display("FAIL redir_ctl got br/inc/rd %b%b%b addr %h want 100 040",
                     pc_branch_en, pc_inc, imem_rd_en, pc_branch_addr);
        end
        step();
        redirect_en = 1'b0;
        checks++;
        if (if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_bubble1 got valid %b pc %h want 0",
                     if_id_valid, if_id_pc);
        end
        step();
        checks++;
        if (if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_bubble2 got valid %b pc %h want 0",
                     if_id_valid, if_id_pc);
        end
        step();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr} !==
            {1'b1, 11'h040, 16'h0140}) begin
            errors++;
            $display("FAIL redir_target got %b/%h/%h want 1/040/0140",
                     if_id_valid, if_id_pc, if_id_instr);
        end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        step();
        checks++;
        if ({if_id_valid, if_id_pc} !== {1'b1, 11'h040}) begin
            errors++;
            $display("FAIL rs_hold got %b/%h want 1/040",
                     if_id_valid, if_id_pc);
        end
        redirect_en = 1'b1;
        redirect_addr = 11'h010;
        #1;
        checks++;
        if ({pc_branch_en, pc_inc} !== 2'b10) begin
            errors++;
            $display("FAIL rs_ctl got br/inc %b%b want 10",
                     pc_branch_en, pc_inc);
        end
        step();
        redirect_en = 1'b0;
        stall = 1'b0;
        checks++;
        if (if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL rs_flush got valid %b pc %h want 0",
                     if_id_valid, if_id_pc);
        end
        step();
        checks++;
        if (if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL rs_skid_gone got valid %b pc %h want 0",
                     if_id_valid, if_id_pc);
        end
        step();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr} !==
            {1'b1, 11'h010, 16'h0110}) begin
            errors++;
            $display("FAIL rs_target got %b/%h/%h want 1/010/0110",
                     if_id_valid, if_id_pc, if_id_instr);
        end
    endtask

    task automatic test_reset_midstream();
        stall = 1'b1;
        step();
        stall = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({pc_inc, imem_rd_en, pc_branch_en} !== 3'b000) begin
            errors++;
            $display("FAIL mid_rst_ctl got inc/rd/br %b%b%b want 000",
                     pc_inc, imem_rd_en, pc_branch_en);
        end
        step();
        rst = 1'b0;
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr} !== 28'd0) begin
            errors++;
            $display("FAIL mid_rst_clr got %b/%h/%h want 0/000/0000",
                     if_id_valid, if_id_pc, if_id_instr);
        end
        #1;
        checks++;
        if ({imem_rd_en, imem_addr} !== {1'b1, 11'd0}) begin
            errors++;
            $display("FAIL mid_rst_issue got rd %b addr %h want 1 000",
                     imem_rd_en, imem_addr);
        end
        step();
        checks++;
        if (if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_noskid got valid %b pc %h want 0",
                     if_id_valid, if_id_pc);
        end
        step();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr} !==
            {1'b1, 11'd0, 16'h0100}) begin
            errors++;
            $display("FAIL mid_rst_restart got %b/%h/%h want 1/000/0100",
                     if_id_valid, if_id_pc, if_id_instr);
        end
    endtask

    task automatic test_wrap();
        logic [10:0] exp_pc [4];
        logic [15:0] exp_in [4];
        exp_pc = '{11'd2045, 11'd2046, 11'd2047, 11'd0};
        exp_in = '{16'h08FD, 16'h08FE, 16'h08FF, 16'h0100};
        redirect_en = 1'b1;
        redirect_addr = 11'd2045;
        step();
        redirect_en = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({if_id_valid, if_id_pc, if_id_instr} !==
                {1'b1, exp_pc[i], exp_in[i]}) begin
                errors++;
                $display("FAIL wrap_%0d got %b/%h/%h want 1/%h/%h",
                         i, if_id_valid, if_id_pc, if_id_instr,
                         exp_pc[i], exp_in[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_reset_midstream();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the MINI-RISC pipeline. It sits directly downstream of program_counter and drives that block's inc/branch controls. Each cycle it issues a read of the synchronous instruction memory at the current PC and tracks the one-cycle in-flight fetch. It absorbs decode stalls with a one-entry skid register, squashes wrong-path fetches on redirect, and presents the IF/ID pipeline register to decode.

Parameters:
ADDR_W, 11, instruction address width; matches program_counter current_addr.
INSTR_W, 16, instruction word width.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high; the same net drives program_counter.
pc_addr  in  ADDR_W  current PC from program_counter.current_addr.
pc_inc  out  1  to program_counter.inc.
pc_branch_en  out  1  to program_counter.branch_en.
pc_branch_addr  out  ADDR_W  to program_counter.branch_addr.
imem_addr  out  ADDR_W  instruction memory read address.
imem_rd_en  out  1  instruction memory read strobe.
imem_rdata  in  INSTR_W  read data; valid exactly 1 cycle after the rd_en cycle; not held afterwards.
stall  in  1  decode cannot accept; IF/ID must hold.
redirect_en  in  1  taken branch/jump from execute; flush and redirect.
redirect_addr  in  ADDR_W  redirect target.
if_id_valid  out  1  IF/ID holds a valid instruction.
if_id_instr  out  INSTR_W  fetched instruction.
if_id_pc  out  ADDR_W  address of if_id_instr.

Behaviour:
- Reset (rst=1 at clk edge): if_id_valid=0, if_id_instr=0, if_id_pc=0, inflight_valid=0, skid_valid=0. While rst=1: pc_inc=0, pc_branch_en=0, imem_rd_en=0.
- issue = ~rst & ~stall & ~redirect_en (combinational).
- imem_addr = pc_addr; imem_rd_en = issue; pc_inc = issue.
- pc_branch_en = redirect_en & ~rst; pc_branch_addr = redirect_addr. Redirect and increment are never both asserted.
- In-flight tracking: at each edge, inflight_valid <= issue and inflight_pc <= pc_addr.
- IF/ID update, in priority order at each edge:
  1. redirect_en=1: if_id_valid<=0, inflight_valid<=0, skid_valid<=0. Redirect overrides stall.
  2. stall=1: IF/ID holds. If inflight_valid=1, then skid <= {imem_rdata, inflight_pc} and skid_valid<=1. skid_valid is never 1 while inflight_valid=1 under stall, because no issue happens during stall.
  3. stall=0, skid_valid=1: IF/ID <= skid, if_id_valid<=1, skid_valid<=0.
  4. stall=0, skid_valid=0: if_id_valid <= inflight_valid; if inflight_valid=1, load if_id_instr<=imem_rdata and if_id_pc<=inflight_pc.
- Case 3 also issues a new fetch; that data lands in IF/ID the next cycle through case 4. No bubble on stall release.
- Latency: fetch issued at cycle N is visible in IF/ID after edge N+1, assuming no stall.
- Throughput: 1 instruction/cycle in steady state.
- Redirect penalty: redirect at cycle R. Target issued at R+1 (pc_addr=redirect_addr). Valid in IF/ID after edge R+2. 2 bubbles.
- Simultaneous redirect and stall: redirect wins; flush, no skid capture.
- Reset mid-stream: in-flight and skid data are discarded; the first issue is in the first cycle with rst=0, at pc_addr=0.
- PC wrap 2047->0 is handled by program_counter; this block passes addresses through unmodified.

Test Plan:
- Reset, then run with no stall; imem[a]=a+16'h100 -> IF/ID shows pc 0,1,2,3 with instr 0x100..0x103 on consecutive cycles; first valid at the 2nd edge after rst falls.
- Stall for 3 cycles starting 1 cycle after fetch of pc 4 -> pc_inc=0 during stall; instr 0x104 captured in skid; IF/ID holds pc 3; on release IF/ID shows pc 4, then pc 5 the next cycle, with no bubble.
- redirect_en with redirect_addr=0x40 while pc 7 is in flight -> pc_branch_en=1, pc_inc=0; pc 7 never becomes valid; if_id_valid=0 for 2 cycles; then pc 0x40 appears with instr 0x140.
- redirect_en and stall asserted together while skid_valid=1 -> skid and IF/ID flushed; target 0x10 appears 2 cycles after stall drops.
- rst asserted for 1 cycle mid-stream with skid_valid=1 -> all valids 0 on the next cycle; fetch restarts at pc 0.
- Run PC to 2047 -> IF/ID shows 2047 then 0 with correct instr, and no spurious bubble.
